ram_port_arbiter: RTL



---
 rtl/ram_port_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one sync-read RAM port among N_REQ requesters; grant and RAM drive
// are combinational, read data returns one cycle after grant; responses are never stalled.
module ram_port_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_BURST  = 4
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_wren,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            req_gnt,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic [ADDR_WIDTH-1:0]       ram_address,
  output logic [DATA_WIDTH-1:0]       ram_data,
  output logic                        ram_wren,
  input  logic [DATA_WIDTH-1:0]       ram_q
);
  localparam int               IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [3:0]       MAX_B = 4'(MAX_BURST);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_REQ - 1);

  logic [IDX_W-1:0] owner_q, owner_d;
  logic [3:0]       burst_cnt_q, burst_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;

  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] cand;
  logic             any_vld;
  logic             others_vld;
  logic             keep;
  logic             found;

  // A zero burst count means the owner was not granted last cycle (reset or idle), so it only
  // retains the port by default when nobody else wants it; otherwise the scan starts past it.
  always_comb begin
    any_vld    = |req_valid;
    others_vld = |(req_valid & ~(N_REQ'(1) << owner_q));
    keep       = req_valid[owner_q] &&
                 (((burst_cnt_q != 4'd0) && (burst_cnt_q < MAX_B)) || !others_vld);
    gnt_idx    = '0;
    cand       = '0;
    found      = 1'b0;
    if (keep) begin
      gnt_idx = owner_q;
      found   = 1'b1;
    end else begin
      for (int k = 1; k <= N_REQ; k++) begin
        cand = IDX_W'((int'(owner_q) + k) % N_REQ);
        if (!found && req_valid[cand]) begin
          found   = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  always_comb begin
    req_gnt     = '0;
    ram_wren    = 1'b0;
    ram_address = req_addr[ADDR_WIDTH-1:0];
    ram_data    = req_wdata[DATA_WIDTH-1:0];
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        ram_address = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_data    = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (any_vld && !rst) begin
      req_gnt[gnt_idx] = 1'b1;
      ram_wren         = req_wren[gnt_idx];
    end
  end

  always_comb begin
    owner_d     = owner_q;
    burst_cnt_d = 4'd0;
    rd_pend_d   = 1'b0;
    rd_idx_d    = rd_idx_q;
    if (any_vld) begin
      if (gnt_idx == owner_q) begin
        burst_cnt_d = (burst_cnt_q < MAX_B) ? burst_cnt_q + 4'd1 : MAX_B;
      end else begin
        owner_d     = gnt_idx;
        burst_cnt_d = 4'd1;
      end
      if (!req_wren[gnt_idx]) begin
        rd_pend_d = 1'b1;
        rd_idx_d  = gnt_idx;
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      owner_q     <= LAST;
      burst_cnt_q <= 4'd0;
      rd_pend_q   <= 1'b0;
      rd_idx_q    <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_idx_q    <= rd_idx_d;
    end
  end

  // Response valid is a pure decode of the read-tag flops, so it is glitch-free and cleared by reset.
  assign rsp_valid = rd_pend_q ? (N_REQ'(1) << rd_idx_q) : '0;
  assign rsp_data  = rd_pend_q ? ram_q : '0;

endmodule
